sla_unit: RTL and testbench



---
 rtl/sla_pkg.sv | 26 ++
 rtl/sla_step.sv | 16 +
 rtl/sla_unit.sv | 108 ++++++++++
 tb/tb_sla_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sla_pkg.sv
// Shared definitions for the sequential arithmetic shift-left unit.
//   state_t    : controller states
//   cnt_width  : bits needed to hold a step count of 0..WIDTH
//   sat_max/sat_min : saturation limits for a WIDTH-bit two's complement value,
//                     returned in 64 bits so callers slice [WIDTH-1:0]
package sla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sla_step.sv
// One combinational shift-left step.
//   i_reg      : current working value
//   o_next_reg : i_reg shifted left by one, zero filled
//   o_step_ovf : this step changes the sign (top two bits differ)
module sla_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_reg,
  output logic [WIDTH-1:0] o_next_reg,
  output logic             o_step_ovf
);

  assign o_next_reg = {i_reg[WIDTH-2:0], 1'b0};
  assign o_step_ovf = i_reg[WIDTH-1] ^ i_reg[WIDTH-2];

endmodule

// File: rtl/sla_unit.sv
// Sequential arithmetic shift-left unit, one bit per clock.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (accepted only in IDLE)
//   in_a, in_b, in_sat  : signed operand, shift amount, saturate enable
//   out_valid/out_ready : result handshake
//   data_out, overflow  : result and sticky signed-overflow flag
// Outputs depend only on state and registers.
module sla_unit
  import sla_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SHW-1:0]   in_b,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             overflow
);

  localparam int unsigned      CW     = cnt_width(WIDTH);
  localparam logic [63:0]      MAXP64 = sat_max(WIDTH);
  localparam logic [63:0]      MINN64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] MAXP   = MAXP64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MINN   = MINN64[WIDTH-1:0];

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_sat;
  logic             r_sign;

  logic [WIDTH-1:0] w_step_reg;
  logic             w_step_ovf;
  logic [CW-1:0]    w_n;
  logic             w_accept;

  sla_step #(.WIDTH(WIDTH)) u_step (
    .i_reg      (r_reg),
    .o_next_reg (w_step_reg),
    .o_step_ovf (w_step_ovf)
  );

  assign w_accept = in_valid && (r_state == IDLE);

  // Amounts of WIDTH or more are clamped: WIDTH steps already clear the
  // register and expose any sign change, so extra steps add nothing.
  always_comb begin
    if (32'(in_b) >= WIDTH) w_n = CW'(WIDTH);
    else                    w_n = CW'(in_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = (w_n == '0) ? DONE : SHIFT;
      SHIFT:   if (r_cnt == CW'(1)) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_sat  <= 1'b0;
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_reg  <= in_a;
      r_cnt  <= w_n;
      r_ovf  <= 1'b0;
      r_sat  <= in_sat;
      r_sign <= in_a[WIDTH-1];
    end else if (r_state == SHIFT) begin
      r_reg <= w_step_reg;
      r_ovf <= r_ovf | w_step_ovf;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    data_out  = '0;
    overflow  = 1'b0;
    if (r_state == DONE) begin
      overflow = r_ovf;
      if (r_ovf && r_sat) data_out = r_sign ? MINN : MAXP;
      else                data_out = r_reg;
    end
  end

endmodule

// File: tb/tb_sla_unit.sv
module tb_sla_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [3:0] in_b;
  logic       in_sat;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data_out;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  sla_unit #(.WIDTH(8), .SHW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sat    (in_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation and collects its result; latency counts sampling
  // points after the accept edge up to the first one showing out_valid.
  // Returns at the falling edge following the result handshake.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input logic s,
                       output logic [7:0] d, output logic o, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_sat = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = data_out;
    o = overflow;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sat = 1'b0; out_ready = 1'b0;
    #2;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic o; int lat;
    do_op(8'h03, 4'd2, 1'b0, d, o, lat);
    n_tests++; if (d !== 8'h0C) begin n_fail++; $display("FAIL basic_data: got %h expected 0c", d); end
    n_tests++; if (o !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", o); end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_hs: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    do_op(8'h03, 4'd2, 1'b1, d, o, lat);
    n_tests++; if (d !== 8'h0C || o !== 1'b0) begin
      n_fail++; $display("FAIL basic_sat_no_ovf: got %h/%b expected 0c/0", d, o);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic o; int lat;
    do_op(8'h40, 4'd1, 1'b0, d, o, lat);
    n_tests++; if (d !== 8'h80 || o !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap: got %h/%b expected 80/1", d, o); end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 2", lat); end
    do_op(8'h40, 4'd1, 1'b1, d, o, lat);
    n_tests++; if (d !== 8'h7F || o !== 1'b1) begin n_fail++; $display("FAIL ovf_sat_pos: got %h/%b expected 7f/1", d, o); end
    do_op(8'hF0, 4'd3, 1'b0, d, o, lat);
    n_tests++; if (d !== 8'h80 || o !== 1'b0) begin n_fail++; $display("FAIL neg_exact: got %h/%b expected 80/0", d, o); end
    do_op(8'hF0, 4'd4, 1'b0, d, o, lat);
    n_tests++; if (d !== 8'h00 || o !== 1'b1) begin n_fail++; $display("FAIL neg_wrap: got %h/%b expected 00/1", d, o); end
    do_op(8'hF0, 4'd4, 1'b1, d, o, lat);
    n_tests++; if (d !== 8'h80 || o !== 1'b1) begin n_fail++; $display("FAIL neg_sat: got %h/%b expected 80/1", d, o); end
  endtask

  task automatic test_clamp();
    logic [7:0] d; logic o; int lat;
    do_op(8'hFF, 4'd9, 1'b1, d, o, lat);
    n_tests++; if (d !== 8'h80 || o !== 1'b1) begin n_fail++; $display("FAIL clamp_sat: got %h/%b expected 80/1", d, o); end
    n_tests++; if (lat != 9) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 9", lat); end
    do_op(8'h00, 4'd15, 1'b0, d, o, lat);
    n_tests++; if (d !== 8'h00 || o !== 1'b0) begin n_fail++; $display("FAIL clamp_zero: got %h/%b expected 00/0", d, o); end
    n_tests++; if (lat != 9) begin n_fail++; $display("FAIL clamp15_latency: got %0d expected 9", lat); end
    do_op(8'h01, 4'd8, 1'b0, d, o, lat);
    n_tests++; if (d !== 8'h00 || o !== 1'b1) begin n_fail++; $display("FAIL clamp_one: got %h/%b expected 00/1", d, o); end
  endtask

  task automatic test_hold();
    int lat;
    @(negedge clk);
    in_a = 8'h5A; in_b = 4'd0; in_sat = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL hold_latency: got %0d expected 1", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; in_a = 8'h11; in_b = 4'd3;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || data_out !== 8'h5A || in_ready !== 1'b0 || overflow !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got v=%b d=%h r=%b o=%b expected 1/5a/0/0", i, out_valid, data_out, in_ready, overflow);
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_no_overlap: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int idx[$];
    @(negedge clk);
    in_a = 8'h03; in_b = 4'd2; in_sat = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (in_ready) idx.push_back(k);
      if (out_valid) begin
        n_tests++; if (data_out !== 8'h0C) begin n_fail++; $display("FAIL b2b_data: got %h expected 0c", data_out); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (idx.size() < 3 || idx[1] - idx[0] != 4 || idx[2] - idx[1] != 4) begin
      n_fail++; $display("FAIL b2b_period: got %0d accepts, first gap %0d expected period 4",
                         idx.size(), (idx.size() > 1) ? idx[1] - idx[0] : -1);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic o; int lat;
    @(negedge clk);
    in_a = 8'h01; in_b = 4'd6; in_sat = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got in_ready=%b expected 0", in_ready); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h00 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got r=%b v=%b d=%h o=%b expected 1/0/00/0", in_ready, out_valid, data_out, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h01, 4'd6, 1'b0, d, o, lat);
    n_tests++; if (d !== 8'h40 || o !== 1'b0) begin n_fail++; $display("FAIL after_reset: got %h/%b expected 40/0", d, o); end
    n_tests++; if (lat != 7) begin n_fail++; $display("FAIL after_reset_latency: got %0d expected 7", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_clamp();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
